// File: rtl/pulse_stretch_pkg.sv
// Shared constants and state encoding for the pulse stretcher.
package pulse_stretch_pkg;
  localparam int DEF_WIDTH        = 16;
  localparam int DEF_MISSED_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;
endpackage

// File: rtl/stretch_down_counter.sv
// Loadable down-counter shared by the delay and active phases; holds at zero.
module stretch_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Turns a strobe rising edge into a delayed pulse of programmable width,
// with optional retrigger and a saturating count of dropped triggers.
//
// state  | meaning
// IDLE   | waiting for a trigger, out low
// DELAY  | counting down the start delay, out low
// ACTIVE | pulse in progress, out high
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int MISSED_WIDTH = DEF_MISSED_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    in,
  input  logic [WIDTH-1:0]        delay,
  input  logic [WIDTH-1:0]        length,
  input  logic                    retrigger,
  input  logic                    clear_missed,
  output logic                    out,
  output logic                    busy,
  output logic [MISSED_WIDTH-1:0] missed_cnt
);

  state_t           state, state_next;
  logic             in_d;
  logic             trig, accept, miss;
  logic [WIDTH-1:0] len_q;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [WIDTH-1:0] cnt_load_val, cnt;

  assign trig = in && !in_d;

  // The last ACTIVE cycle accepts a new trigger so pulses can chain gap-free.
  assign accept = trig && ((state == IDLE) || retrigger ||
                           ((state == ACTIVE) && cnt_zero));
  assign miss   = trig && !accept;

  always_comb begin
    state_next   = state;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = '0;
    case (state)
      DELAY: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_next   = ACTIVE;
          cnt_load     = 1'b1;
          cnt_load_val = len_q - WIDTH'(1);
        end
      end
      ACTIVE: begin
        cnt_en = 1'b1;
        if (cnt_zero) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      if (length == '0) begin
        state_next = IDLE;
      end else if (delay == '0) begin
        state_next   = ACTIVE;
        cnt_load     = 1'b1;
        cnt_load_val = length - WIDTH'(1);
      end else begin
        state_next   = DELAY;
        cnt_load     = 1'b1;
        cnt_load_val = delay - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_d       <= 1'b0;
      len_q      <= '0;
      out        <= 1'b0;
      busy       <= 1'b0;
      missed_cnt <= '0;
    end else begin
      state <= state_next;
      in_d  <= in;
      out   <= (state_next == ACTIVE);
      busy  <= (state_next != IDLE);
      if (accept) len_q <= length;
      if (clear_missed) begin
        missed_cnt <= '0;
      end else if (miss && (missed_cnt != {MISSED_WIDTH{1'b1}})) begin
        missed_cnt <= missed_cnt + MISSED_WIDTH'(1);
      end
    end
  end

  stretch_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch: vector table plus pulse scoreboard.
module tb_pulse_stretch;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        in;
  logic [15:0] delay;
  logic [15:0] length;
  logic        retrigger;
  logic        clear_missed;
  logic        out;
  logic        busy;
  logic [7:0]  missed_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_missed = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int rise;
    int width;
  } pulse_t;
  pulse_t exp_q[$];

  // delay, length, retrigger, second-trigger gap (0 = none),
  // expected pulses (rise offset from accept edge, width; width 0 = none), misses
  typedef struct {
    int d; int l; int r; int gap;
    int r0; int w0; int r1; int w1;
    int miss;
  } vec_t;

  pulse_stretch dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .in           (in),
    .delay        (delay),
    .length       (length),
    .retrigger    (retrigger),
    .clear_missed (clear_missed),
    .out          (out),
    .busy         (busy),
    .missed_cnt   (missed_cnt)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Observes out on the falling edge, measures each pulse and matches it against the queue.
  initial begin
    bit     prev = 1'b0;
    int     rise_c = 0;
    pulse_t e;
    forever begin
      @(negedge clk_in);
      if (!mon_en) begin
        prev = 1'b0;
      end else begin
        if (out && !prev) rise_c = cyc;
        if (!out && prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse_rise", rise_c, -1);
          end else begin
            e = exp_q.pop_front();
            check("pulse_rise", rise_c, e.rise);
            check("pulse_width", cyc - rise_c, e.width);
          end
        end
        prev = out;
      end
    end
  end

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy || out) && n < maxc) begin
      @(negedge clk_in);
      n++;
    end
    check("idle_busy", int'(busy), 0);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic push_pulse(input int rise, input int width);
    pulse_t p;
    p.rise  = rise;
    p.width = width;
    exp_q.push_back(p);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int e_edge;
    @(negedge clk_in);
    delay     = 16'(v.d);
    length    = 16'(v.l);
    retrigger = v.r[0];
    e_edge    = cyc + 1;
    if (v.w0 > 0) push_pulse(e_edge + v.r0, v.w0);
    if (v.w1 > 0) push_pulse(e_edge + v.r1, v.w1);
    in = 1'b1;
    @(negedge clk_in);
    in = 1'b0;
    if (v.gap > 0) begin
      repeat (v.gap - 1) @(negedge clk_in);
      in = 1'b1;
      @(negedge clk_in);
      in = 1'b0;
    end
    // Inputs are only sampled on accepted triggers; scramble them afterwards.
    delay  = 16'($urandom_range(0, 40));
    length = 16'($urandom_range(0, 40));
    wait_idle(200);
    exp_missed = (exp_missed + v.miss > 255) ? 255 : exp_missed + v.miss;
    check($sformatf("vec%0d_missed_cnt", idx), int'(missed_cnt), exp_missed);
  endtask

  initial begin
    vec_t vecs[10];
    int   e_edge;

    vecs[0] = '{d:3, l:5,  r:0, gap:0, r0:3, w0:5,  r1:0, w1:0, miss:0};
    vecs[1] = '{d:0, l:1,  r:0, gap:0, r0:0, w0:1,  r1:0, w1:0, miss:0};
    vecs[2] = '{d:0, l:0,  r:0, gap:0, r0:0, w0:0,  r1:0, w1:0, miss:0};
    vecs[3] = '{d:0, l:10, r:0, gap:4, r0:0, w0:10, r1:0, w1:0, miss:1};
    vecs[4] = '{d:0, l:10, r:1, gap:4, r0:0, w0:14, r1:0, w1:0, miss:0};
    vecs[5] = '{d:0, l:4,  r:0, gap:4, r0:0, w0:8,  r1:0, w1:0, miss:0};
    vecs[6] = '{d:5, l:3,  r:1, gap:2, r0:7, w0:3,  r1:0, w1:0, miss:0};
    vecs[7] = '{d:5, l:3,  r:0, gap:2, r0:5, w0:3,  r1:0, w1:0, miss:1};
    vecs[8] = '{d:2, l:3,  r:1, gap:4, r0:2, w0:2,  r1:6, w1:3, miss:0};
    vecs[9] = '{d:1, l:1,  r:0, gap:0, r0:1, w0:1,  r1:0, w1:0, miss:0};

    rst_n = 1'b0; in = 1'b0; delay = '0; length = '0;
    retrigger = 1'b0; clear_missed = 1'b0;
    #12;
    check("rst_out", int'(out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_missed_cnt", int'(missed_cnt), 0);
    @(negedge clk_in);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // busy tracks the delay phase as well as the pulse
    @(negedge clk_in);
    delay = 16'd2; length = 16'd2; retrigger = 1'b0;
    e_edge = cyc + 1;
    push_pulse(e_edge + 2, 2);
    in = 1'b1;
    @(negedge clk_in);
    in = 1'b0;
    check("busy_in_delay", int'(busy), 1);
    check("out_in_delay", int'(out), 0);
    wait_idle(50);

    // held-high input gives exactly one pulse even with retrigger enabled
    @(negedge clk_in);
    delay = 16'd0; length = 16'd3; retrigger = 1'b1;
    push_pulse(cyc + 1, 3);
    in = 1'b1;
    repeat (12) @(negedge clk_in);
    in = 1'b0;
    wait_idle(50);

    // 300 dropped triggers saturate the missed counter
    @(negedge clk_in);
    delay = 16'd0; length = 16'd700; retrigger = 1'b0;
    push_pulse(cyc + 1, 700);
    in = 1'b1;
    @(negedge clk_in);
    in = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in); in = 1'b1;
      @(negedge clk_in); in = 1'b0;
    end
    wait_idle(1000);
    exp_missed = 255;
    check("missed_saturated", int'(missed_cnt), exp_missed);

    // clear wins over a coincident miss
    @(negedge clk_in);
    delay = 16'd0; length = 16'd10; retrigger = 1'b0;
    push_pulse(cyc + 1, 10);
    in = 1'b1;
    @(negedge clk_in);
    in = 1'b0;
    repeat (3) @(negedge clk_in);
    in = 1'b1; clear_missed = 1'b1;
    @(negedge clk_in);
    in = 1'b0; clear_missed = 1'b0;
    exp_missed = 0;
    check("clear_vs_miss", int'(missed_cnt), exp_missed);
    wait_idle(50);

    // asynchronous reset in the middle of a pulse
    mon_en = 1'b0;
    @(negedge clk_in);
    delay = 16'd0; length = 16'd20; retrigger = 1'b0;
    in = 1'b1;
    @(negedge clk_in);
    in = 1'b0;
    repeat (4) @(negedge clk_in);
    check("pre_reset_out", int'(out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", int'(out), 0);
    check("async_reset_busy", int'(busy), 0);

    // input already high when reset releases triggers on the first edge
    delay = 16'd0; length = 16'd2; in = 1'b1;
    @(negedge clk_in);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push_pulse(cyc + 1, 2);
    repeat (6) @(negedge clk_in);
    in = 1'b0;
    wait_idle(50);
    check("post_reset_missed_cnt", int'(missed_cnt), 0);

    repeat (3) @(negedge clk_in);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
